// File: rtl/uart2vga_pkg.sv
// Shared definitions for the UART-to-VGA row link: frame layout, answer
// codes and the row sender state encoding.
package uart2vga_pkg;

  // Frame layout: Y high, Y low, pixel bytes, stop byte.
  localparam int BYTE_SIZE_ROW  = 240;
  localparam int BYTE_SIZE_Y    = 2;
  localparam int BYTE_SIZE_STOP = 1;
  localparam int FRAME_BYTES    = BYTE_SIZE_Y + BYTE_SIZE_ROW + BYTE_SIZE_STOP;

  // Byte values on the wire.
  localparam logic [7:0] STOP_BYTE             = 8'hDD;
  localparam logic [7:0] SUCCESSFULLY_RECEIVED = 8'hFF;
  localparam logic [7:0] NOT_ALL_RECEIVED      = 8'h11;
  // The one answer code the responder sends when it accepts a frame.
  localparam logic [7:0] ANSWER_CODE           = SUCCESSFULLY_RECEIVED;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    STROBE,
    WAIT_BUSY_H,
    WAIT_BUSY_L,
    NEXT,
    WAIT_ANS,
    RESULT
  } sender_state_t;

endpackage

// File: rtl/uart_answer_timer.sv
// Answer watchdog for the row sender: counts cycles while an answer is
// awaited and decodes the received byte into ok / fail / timeout.
// A byte arriving in the expiry cycle wins over the timeout.
module uart_answer_timer
  import uart2vga_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       ans_ok,
  output logic       ans_fail,
  output logic       timeout
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Cleared whenever no answer is awaited; saturates at the last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt != CNT_LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign ans_ok   = en && rx_done && (rx_data == ANSWER_CODE);
  assign ans_fail = en && rx_done && (rx_data != ANSWER_CODE);
  assign timeout  = en && !rx_done && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_row_sender.sv
// Row sender: streams one image row as a UART frame (Y high, Y low,
// BYTE_SIZE_ROW pixels, stop byte) and, when ANSWER_CHECK_EN is defined,
// waits for the responder's answer and retries on failure or timeout.
// Without ANSWER_CHECK_EN the frame is reported good right after the stop byte.
//
// Transmitter handshake: start_strobe is a one-cycle request carrying
// tx_data; the transmitter acknowledges by raising busy, and the byte is
// finished when busy falls again. tx_data is held until then.
module uart_row_sender
  import uart2vga_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRY      = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             send_req,
  input  logic [15:0]                      row_y,
  output logic [$clog2(BYTE_SIZE_ROW)-1:0] rd_addr,
  input  logic [7:0]                       rd_data,
  output logic                             start_strobe,
  output logic [7:0]                       tx_data,
  input  logic                             busy,
  input  logic [7:0]                       rx_data,
  input  logic                             rx_done,
  output logic                             ready,
  output logic                             frame_done,
  output logic                             frame_ok,
  output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt,
  output sender_state_t                    state_dbg
);

  localparam int ADDR_W  = $clog2(BYTE_SIZE_ROW);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int IDX_W   = $clog2(FRAME_BYTES);

  localparam logic [IDX_W-1:0]   IDX_FIRST_PIX = IDX_W'(BYTE_SIZE_Y);
  localparam logic [IDX_W-1:0]   IDX_STOP      = IDX_W'(BYTE_SIZE_Y + BYTE_SIZE_ROW);
  localparam logic [RETRY_W-1:0] RETRY_MAX     = RETRY_W'(MAX_RETRY);

  sender_state_t    state, state_nxt;
  logic [IDX_W-1:0] idx, idx_inc;
  logic [15:0]      row_y_q;
  logic             fetch_wait;
  logic [7:0]       byte_sel;
  logic             is_pixel, is_stop, retry_left;
  logic             ans_en, ans_ok, ans_fail, ans_timeout;

  function automatic logic pixel_index(input logic [IDX_W-1:0] i);
    return (i >= IDX_FIRST_PIX) && (i < IDX_STOP);
  endfunction

  assign idx_inc    = idx + 1'b1;
  assign is_pixel   = pixel_index(idx);
  assign is_stop    = (idx == IDX_STOP);
  assign retry_left = (retry_cnt < RETRY_MAX);
  assign ans_en     = (state == WAIT_ANS);

`ifdef ANSWER_CHECK_EN
  localparam bit ANSWER_CHECK = 1'b1;

  uart_answer_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_answer_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (ans_en),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .ans_ok   (ans_ok),
    .ans_fail (ans_fail),
    .timeout  (ans_timeout)
  );
`else
  localparam bit ANSWER_CHECK = 1'b0;

  logic unused_answer;
  assign unused_answer = ^{rx_data, rx_done, ans_en, (TIMEOUT_CYCLES > 1)};
  assign ans_ok        = 1'b0;
  assign ans_fail      = 1'b0;
  assign ans_timeout   = 1'b0;
`endif

  // Byte to send for the current frame index.
  always_comb begin
    byte_sel = rd_data;
    if (idx == '0) begin
      byte_sel = row_y_q[15:8];
    end else if (idx == IDX_W'(1)) begin
      byte_sel = row_y_q[7:0];
    end else if (is_stop) begin
      byte_sel = STOP_BYTE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (send_req) state_nxt = FETCH;
      FETCH:       if (!is_pixel || fetch_wait) state_nxt = STROBE;
      STROBE:      state_nxt = WAIT_BUSY_H;
      WAIT_BUSY_H: if (busy) state_nxt = WAIT_BUSY_L;
      WAIT_BUSY_L: if (!busy) state_nxt = NEXT;
      NEXT: begin
        if (is_stop) begin
          state_nxt = ANSWER_CHECK ? WAIT_ANS : RESULT;
        end else begin
          state_nxt = FETCH;
        end
      end
      WAIT_ANS: begin
        if (ans_ok) begin
          state_nxt = RESULT;
        end else if (ans_fail || ans_timeout) begin
          state_nxt = retry_left ? FETCH : RESULT;
        end
      end
      RESULT:      state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // Frame datapath: index, row buffer address, byte register, result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      row_y_q    <= '0;
      fetch_wait <= 1'b0;
      tx_data    <= '0;
      rd_addr    <= '0;
      retry_cnt  <= '0;
      frame_ok   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (send_req) begin
            row_y_q    <= row_y;
            idx        <= '0;
            fetch_wait <= 1'b0;
            retry_cnt  <= '0;
            frame_ok   <= 1'b0;
          end
        end
        FETCH: begin
          // Pixel bytes spend one extra cycle here for the buffer read.
          if (is_pixel && !fetch_wait) begin
            fetch_wait <= 1'b1;
          end else begin
            fetch_wait <= 1'b0;
            tx_data    <= byte_sel;
          end
        end
        NEXT: begin
          if (is_stop) begin
            if (!ANSWER_CHECK) frame_ok <= 1'b1;
          end else begin
            idx <= idx_inc;
            // Present the address early so data is ready in FETCH.
            if (pixel_index(idx_inc)) rd_addr <= ADDR_W'(idx_inc - IDX_FIRST_PIX);
          end
        end
        WAIT_ANS: begin
          if (ans_ok) begin
            frame_ok <= 1'b1;
          end else if (ans_fail || ans_timeout) begin
            if (retry_left) begin
              retry_cnt <= retry_cnt + 1'b1;
              idx       <= '0;
            end else begin
              frame_ok <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ready        = (state == IDLE);
  assign start_strobe = (state == STROBE);
  assign frame_done   = (state == RESULT);
  assign state_dbg    = state;

endmodule

// File: doc/uart_row_sender.md
# uart_row_sender

Host-side initiator for the UART-to-VGA row link. On request it reads one image row from a byte buffer and streams it as a frame (2 Y bytes, BYTE_SIZE_ROW pixel bytes, stop byte) through the byte-level UART transmitter. It then waits for the responder's one-byte answer from the UART receiver and retries the whole frame on a failure or a timeout. It sits between a row buffer and the existing uart_transmiter/uart_receiver pair, driving the same protocol that uart2vga_with_answer terminates.

## Interface
- BYTE_SIZE_ROW, 240, pixel bytes per frame
- STOP_BYTE, 8'hDD, frame terminator
- SUCCESSFULLY_RECEIVED, 8'hFF, answer meaning frame accepted
- NOT_ALL_RECEIVED, 8'h11, answer meaning frame incomplete
- TIMEOUT_CYCLES, 50000, clk cycles to wait for an answer
- MAX_RETRY, 3, retransmissions after the first attempt
- clk  in  1  system clock; the block uses one clock only
- rst_n  in  1  asynchronous, active-low reset
- send_req  in  1  one-cycle pulse that starts a frame; ignored unless idle
- row_y  in  16  row number, captured on an accepted send_req
- rd_addr  out  $clog2(BYTE_SIZE_ROW)  row buffer read address
- rd_data  in  8  row buffer data, valid 1 cycle after rd_addr
- start_strobe  out  1  one-cycle start pulse to the transmitter
- tx_data  out  8  byte to transmit, held stable until busy falls
- busy  in  1  transmitter busy
- rx_data  in  8  received answer byte
- rx_done  in  1  received-byte strobe
- ready  out  1  high while idle
- frame_done  out  1  one-cycle pulse when the frame completes
- frame_ok  out  1  result flag, valid with frame_done and held until the next accepted send_req
- retry_cnt  out  $clog2(MAX_RETRY+1)  retries used for the current or last frame

## Operation
- States: IDLE, FETCH, STROBE, WAIT_BUSY_H, WAIT_BUSY_L, NEXT, WAIT_ANS, RESULT.
- IDLE: ready=1. On send_req, latch row_y, clear retry_cnt and frame_ok, set byte index to 0, go to FETCH.
- Byte order by index:
  - index 0 sends row_y[15:8].
  - index 1 sends row_y[7:0].
  - indices 2..BYTE_SIZE_ROW+1 send the pixel bytes rd_data, with rd_addr = index-2.
  - index BYTE_SIZE_ROW+2 sends STOP_BYTE.
- FETCH: drive rd_addr. Wait 1 cycle when the index is a pixel byte, 0 extra cycles otherwise. Register tx_data, go to STROBE.
- STROBE: start_strobe=1 for exactly one cycle, go to WAIT_BUSY_H.
- WAIT_BUSY_H: wait for busy=1, then go to WAIT_BUSY_L.
- WAIT_BUSY_L: wait for busy=0, then go to NEXT.
- NEXT: if the stop byte was just sent, go to WAIT_ANS. Otherwise increment the index and go to FETCH.
- WAIT_ANS: clear the timeout counter on entry.
  - rx_done with rx_data==SUCCESSFULLY_RECEIVED: set frame_ok=1, go to RESULT.
  - rx_done with any other byte (including NOT_ALL_RECEIVED), or the counter reaching TIMEOUT_CYCLES-1: treat as a failed attempt.
- Failed attempt:
  - If retry_cnt<MAX_RETRY: increment retry_cnt, reset the index to 0, go to FETCH.
  - Otherwise set frame_ok=0, go to RESULT.
- RESULT: frame_done=1 for one cycle, go to IDLE.
- rx_done outside WAIT_ANS is ignored. An rx_done in the same cycle as the timeout expiry takes priority: the byte is evaluated, not the timeout.
- send_req outside IDLE is ignored; it is not queued.

## Timing
- Reset values: ready=1; start_strobe=0, frame_done=0, frame_ok=0; tx_data=0, rd_addr=0, retry_cnt=0; state IDLE.
- Reset asserted mid-frame aborts immediately. No partial-frame recovery; the responder resynchronises on the stop byte.
- Latency from accepted send_req to the first start_strobe: 2 cycles (FETCH, then STROBE).
- Gap between the busy falling edge and the next start_strobe: 3 cycles for a pixel byte, 2 otherwise.
- One frame is BYTE_SIZE_ROW+3 bytes, so 243 start_strobe pulses per attempt.
- The timeout counter is $clog2(TIMEOUT_CYCLES) bits wide and saturates; it never wraps.

## Configuration
- ANSWER_CHECK_EN defined: answer handling, timeout and retries are implemented as described above.
- ANSWER_CHECK_EN undefined:
  - NEXT goes directly to RESULT after the stop byte, with frame_ok=1.
  - retry_cnt is held at 0.
  - rx_data and rx_done are unused, and the timeout counter is not built.

## Structure
- Shared package uart2vga_pkg holds:
  - the state typedef;
  - STOP_BYTE, SUCCESSFULLY_RECEIVED, NOT_ALL_RECEIVED and ANSWER_CODE;
  - BYTE_SIZE_ROW, BYTE_SIZE_Y and BYTE_SIZE_STOP.
- One sub-module, uart_answer_timer: the timeout counter plus answer-byte decode, producing ans_ok, ans_fail and timeout. It is instantiated only under ANSWER_CHECK_EN.

## Test plan
- **Clean frame.** row_y=16'h0012 with a random row buffer and a bench responder that answers 8'hFF.
  - Required: the bench receives 00, 12, the 240 buffer bytes in order, then DD.
  - Then frame_done pulses once with frame_ok=1 and retry_cnt=0.
- **Incomplete answer.** The responder answers 8'h11 once, then 8'hFF.
  - Required: the frame is sent twice, byte-identical; the result is frame_ok=1, retry_cnt=1.
- **No answer.** The responder never answers, TIMEOUT_CYCLES=1000, MAX_RETRY=3.
  - Required: 4 full frames are sent, then frame_done with frame_ok=0 and retry_cnt=3.
- **Reset mid-frame.** rst_n is pulled low after byte 100.
  - Required: all outputs take their reset values asynchronously and no further start_strobe appears.
  - A new send_req then produces a complete, correct frame.
- **Request while active.** send_req is pulsed during WAIT_BUSY_L.
  - Required: it is ignored, exactly one frame is produced, and row_y is unchanged.
- **Stray byte.** A stray rx_done=1 arrives during pixel transmission (ANSWER_CHECK_EN defined).
  - Required: it is ignored, and the result is decided only by the post-stop answer.
